// File: rtl/adder_serial_pkg.sv
// Shared types for the serial adder: FSM state encoding only, since all
// widths are per-instance parameters.
package adder_serial_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_CALC,
        STATE_DONE
    } state_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational ripple-carry adder of parametrised width; one chunk of the
// serial adder's per-cycle work.
module adder_chunk #(
    parameter int unsigned nbits = 1
) (
    input  logic [nbits-1:0] a,
    input  logic [nbits-1:0] b,
    input  logic             cin,
    output logic [nbits-1:0] sum,
    output logic             cout
);

    logic c;

    always_comb begin
        sum = '0;
        c   = cin;
        for (int unsigned i = 0; i < nbits; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/adder_serial.sv
// Multi-cycle adder: iterates a chunk_nbits-wide ripple adder over the
// operands, one chunk per cycle, behind val/rdy handshakes on both sides.
module adder_serial
    import adder_serial_pkg::*;
#(
    parameter int unsigned nbits       = 32,
    parameter int unsigned chunk_nbits = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [nbits-1:0] in0,
    input  logic [nbits-1:0] in1,
    input  logic             cin,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [nbits-1:0] sum,
    output logic             cout
);

    localparam int unsigned nchunks = nbits / chunk_nbits;
    localparam int unsigned cnt_w   = $clog2(nchunks) + 1;
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(nchunks - 1);

    if (nbits < 1 || chunk_nbits < 1 || (nbits % chunk_nbits) != 0) begin : g_bad_params
        $error("adder_serial: chunk_nbits must be >= 1 and divide nbits exactly");
    end

    state_t                 state;
    logic [nbits-1:0]       a_reg;
    logic [nbits-1:0]       b_reg;
    logic [nbits-1:0]       sum_reg;
    logic                   carry;
    logic [cnt_w-1:0]       cnt;
    logic [chunk_nbits-1:0] chunk_sum;
    logic                   chunk_cout;
    logic [nbits-1:0]       sum_shift;

    adder_chunk #(
        .nbits (chunk_nbits)
    ) u_chunk (
        .a    (a_reg[chunk_nbits-1:0]),
        .b    (b_reg[chunk_nbits-1:0]),
        .cin  (carry),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    // Shift-based insert keeps the nchunks == 1 case free of empty slices.
    always_comb begin
        sum_shift = (sum_reg >> chunk_nbits) | (nbits'(chunk_sum) << (nbits - chunk_nbits));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= STATE_IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            sum_reg     <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            istream_rdy <= 1'b0;
            ostream_val <= 1'b0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    istream_rdy <= 1'b1;
                    if (istream_val && istream_rdy) begin
                        a_reg       <= in0;
                        b_reg       <= in1;
                        carry       <= cin;
                        cnt         <= '0;
                        istream_rdy <= 1'b0;
                        state       <= STATE_CALC;
                    end
                end
                STATE_CALC: begin
                    sum_reg <= sum_shift;
                    a_reg   <= a_reg >> chunk_nbits;
                    b_reg   <= b_reg >> chunk_nbits;
                    carry   <= chunk_cout;
                    cnt     <= cnt + 1'b1;
                    if (cnt == last_cnt) begin
                        ostream_val <= 1'b1;
                        state       <= STATE_DONE;
                    end
                end
                STATE_DONE: begin
                    if (ostream_rdy) begin
                        ostream_val <= 1'b0;
                        istream_rdy <= 1'b1;
                        state       <= STATE_IDLE;
                    end
                end
                default: begin
                    state <= STATE_IDLE;
                end
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = carry;

endmodule

// File: tb/tb_adder_serial.sv
// Directed checks of adder_serial across several width/chunk configurations,
// with hand-computed sums, latencies, backpressure and mid-calculation reset.
module tb_adder_serial;

    localparam int unsigned NDUT = 7;
    // 0:8/1 1:8/2 2:32/8 3:16/1 4:32/4 5:32/32 6:32/1
    localparam int unsigned NBITS [NDUT] = '{8, 8, 32, 16, 32, 32, 32};
    localparam int unsigned CBITS [NDUT] = '{1, 2, 8, 1, 4, 32, 1};

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        cin;
    logic        ostream_rdy;
    logic        ival   [NDUT];
    logic        irdy   [NDUT];
    logic        oval   [NDUT];
    logic        cout_a [NDUT];
    logic [31:0] sum_a  [NDUT];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned NB = NBITS[g];
        localparam int unsigned CB = CBITS[g];
        logic [NB-1:0] s;

        adder_serial #(
            .nbits       (NB),
            .chunk_nbits (CB)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .istream_val (ival[g]),
            .istream_rdy (irdy[g]),
            .in0         (in0[NB-1:0]),
            .in1         (in1[NB-1:0]),
            .cin         (cin),
            .ostream_val (oval[g]),
            .ostream_rdy (ostream_rdy),
            .sum         (s),
            .cout        (cout_a[g])
        );

        assign sum_a[g] = 32'(s);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on DUT idx; holds ostream_rdy low for `hold` cycles in DONE.
    task automatic do_txn(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic [31:0] es, input logic ec,
                          input int lat, input int hold);
        int cyc;
        cyc = 0;
        while (!irdy[idx] && cyc < 50) begin
            tick();
            cyc++;
        end
        check($sformatf("d%0d rdy_wait", idx), 64'(irdy[idx]), 64'd1);
        in0       = a;
        in1       = b;
        cin       = c;
        ival[idx] = 1'b1;
        tick();
        ival[idx] = 1'b0;
        in0       = ~a;
        in1       = 32'h5A5A_A5A5;
        cin       = ~c;
        cyc       = 0;
        while (!oval[idx] && cyc < 100) begin
            tick();
            cyc++;
        end
        check($sformatf("d%0d latency", idx), 64'(cyc), 64'(lat));
        check($sformatf("d%0d sum", idx), 64'(sum_a[idx]), 64'(es));
        check($sformatf("d%0d cout", idx), 64'(cout_a[idx]), 64'(ec));
        check($sformatf("d%0d rdy_in_done", idx), 64'(irdy[idx]), 64'd0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check($sformatf("d%0d hold_val", idx), 64'(oval[idx]), 64'd1);
            check($sformatf("d%0d hold_rdy", idx), 64'(irdy[idx]), 64'd0);
            check($sformatf("d%0d hold_sum", idx), 64'(sum_a[idx]), 64'(es));
            check($sformatf("d%0d hold_cout", idx), 64'(cout_a[idx]), 64'(ec));
        end
        ostream_rdy = 1'b1;
        tick();
        ostream_rdy = 1'b0;
        check($sformatf("d%0d post_val", idx), 64'(oval[idx]), 64'd0);
        check($sformatf("d%0d post_rdy", idx), 64'(irdy[idx]), 64'd1);
    endtask

    initial begin
        int seen;
        reset       = 1'b1;
        in0         = '0;
        in1         = '0;
        cin         = 1'b0;
        ostream_rdy = 1'b0;
        for (int i = 0; i < NDUT; i++) ival[i] = 1'b0;

        repeat (2) tick();
        check("rst_rdy_low", 64'(irdy[0]), 64'd0);
        reset = 1'b0;
        tick();
        check("rst_rdy", 64'(irdy[0]), 64'd1);
        check("rst_val", 64'(oval[0]), 64'd0);
        check("rst_sum", 64'(sum_a[0]), 64'h00);
        check("rst_cout", 64'(cout_a[0]), 64'd0);

        do_txn(0, 32'h35, 32'h4A, 1'b0, 32'h7F, 1'b0, 8, 0);
        do_txn(1, 32'hFF, 32'h00, 1'b1, 32'h00, 1'b1, 4, 0);
        do_txn(1, 32'hFF, 32'hFF, 1'b1, 32'hFF, 1'b1, 4, 0);
        do_txn(2, 32'h89AB_CDEF, 32'h7654_3210, 1'b0, 32'hFFFF_FFFF, 1'b0, 4, 10);
        do_txn(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 4, 0);
        do_txn(4, 32'h1234_5678, 32'h8765_4321, 1'b1, 32'h9999_999A, 1'b0, 8, 0);
        do_txn(4, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1, 8, 2);
        do_txn(5, 32'hDEAD_BEEF, 32'h2152_4110, 1'b1, 32'h0000_0000, 1'b1, 1, 0);
        do_txn(5, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0000_000C, 1'b0, 1, 0);
        do_txn(6, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, 32'hFFFF_FFFF, 1'b0, 32, 0);

        // Abort a 16/1 transaction five edges after accept.
        in0     = 32'h0000_FFFF;
        in1     = 32'h0000_FFFF;
        cin     = 1'b1;
        ival[3] = 1'b1;
        tick();
        ival[3] = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_sum_cleared", 64'(sum_a[3]), 64'd0);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (oval[3]) seen++;
            tick();
        end
        check("abort_no_val", 64'(seen), 64'd0);
        do_txn(3, 32'h1234, 32'h0FFF, 1'b0, 32'h2233, 1'b0, 16, 0);
        do_txn(3, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 16, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
